// File: rtl/vrom_arbiter_if.sv
// Purpose: bundles the two GPU read ports and the shared image-ROM port of vrom_arbiter.
// Latency: none; wires only.
// Backpressure: none; requesters must take every valid pulse, and req is held until gnt.
interface vrom_arbiter_if #(
  parameter int AW = 8,
  parameter int IW = 3,
  parameter int CW = 3
);
  logic          en_f2;
  logic          en_f3;

  logic          f2_req;
  logic [AW-1:0] f2_addr;
  logic [IW-1:0] f2_index;
  logic          f2_gnt;
  logic          f2_valid;
  logic [CW-1:0] f2_data;

  logic          f3_req;
  logic [AW-1:0] f3_addr;
  logic [IW-1:0] f3_index;
  logic          f3_gnt;
  logic          f3_valid;
  logic [CW-1:0] f3_data;

  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_index;
  logic [CW-1:0] rom_data;

  // Arbiter side
  modport slave (
    input  en_f2, en_f3,
    input  f2_req, f2_addr, f2_index,
    input  f3_req, f3_addr, f3_index,
    input  rom_data,
    output f2_gnt, f2_valid, f2_data,
    output f3_gnt, f3_valid, f3_data,
    output rom_en, rom_addr, rom_index
  );

  // Requester / ROM side
  modport master (
    output en_f2, en_f3,
    output f2_req, f2_addr, f2_index,
    output f3_req, f3_addr, f3_index,
    output rom_data,
    input  f2_gnt, f2_valid, f2_data,
    input  f3_gnt, f3_valid, f3_data,
    input  rom_en, rom_addr, rom_index
  );
endinterface

// File: rtl/vrom_arbiter.sv
// Purpose: round-robin sharing of one single-port image ROM between func2 and func3 GPUs.
// Latency: req in cycle N -> gnt/rom_en at N+1 -> valid/data at N+2+ROM_LAT.
// Backpressure: none; returns are pushed to the owner, a requester gets at most 1 gnt per 2 cycles.
module vrom_arbiter #(
  parameter int ROM_LAT = 1,  // ROM read latency, 1..4
  parameter int AW      = 8,
  parameter int IW      = 3,
  parameter int CW      = 3
) (
  input logic           sysclk,
  input logic           rst_n,
  vrom_arbiter_if.slave vrom_bus
);

  typedef enum logic {OWN_F2 = 1'b0, OWN_F3 = 1'b1} owner_e;

  // One tag stage per cycle from issue until rom_data is valid
  localparam int NSTG = ROM_LAT + 1;

  owner_e          r_last_owner;
  logic            r_f2_gnt;
  logic            r_f3_gnt;
  logic            r_rom_en;
  logic [AW-1:0]   r_rom_addr;
  logic [IW-1:0]   r_rom_index;
  logic [NSTG-1:0] r_tag_vld;
  logic [NSTG-1:0] r_tag_f3;
  logic            r_f2_valid;
  logic            r_f3_valid;
  logic [CW-1:0]   r_f2_data;
  logic [CW-1:0]   r_f3_data;

  logic            w_eff_f2;
  logic            w_eff_f3;
  logic            w_win_f2;
  logic            w_win_f3;
  logic            w_ret_f2;
  logic            w_ret_f3;

  // Eligibility, round-robin pick and return steering from the oldest tag stage
  always_comb begin
    // A request seen in its own grant cycle has already been issued
    w_eff_f2 = vrom_bus.f2_req & vrom_bus.en_f2 & ~r_f2_gnt;
    w_eff_f3 = vrom_bus.f3_req & vrom_bus.en_f3 & ~r_f3_gnt;
    w_win_f2 = w_eff_f2 & (~w_eff_f3 | (r_last_owner == OWN_F3));
    w_win_f3 = w_eff_f3 & ~w_win_f2;
    w_ret_f2 = r_tag_vld[ROM_LAT] & ~r_tag_f3[ROM_LAT];
    w_ret_f3 = r_tag_vld[ROM_LAT] &  r_tag_f3[ROM_LAT];
  end

  // Grant pulses and ROM command; address/index hold when nobody wins
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_F3;
      r_f2_gnt     <= 1'b0;
      r_f3_gnt     <= 1'b0;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_index  <= '0;
    end else begin
      r_f2_gnt <= w_win_f2;
      r_f3_gnt <= w_win_f3;
      r_rom_en <= w_win_f2 | w_win_f3;
      if (w_win_f2) begin
        r_rom_addr   <= vrom_bus.f2_addr;
        r_rom_index  <= vrom_bus.f2_index;
        r_last_owner <= OWN_F2;
      end else if (w_win_f3) begin
        r_rom_addr   <= vrom_bus.f3_addr;
        r_rom_index  <= vrom_bus.f3_index;
        r_last_owner <= OWN_F3;
      end
    end
  end

  // Tag pipe: stage 0 mirrors rom_en, the last stage lines up with valid rom_data
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_f3  <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[NSTG-2:0], w_win_f2 | w_win_f3};
      r_tag_f3  <= {r_tag_f3[NSTG-2:0], w_win_f3};
    end
  end

  // Capture rom_data into the owner's data register; data holds between pulses
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_f2_valid <= 1'b0;
      r_f3_valid <= 1'b0;
      r_f2_data  <= '0;
      r_f3_data  <= '0;
    end else begin
      r_f2_valid <= w_ret_f2;
      r_f3_valid <= w_ret_f3;
      if (w_ret_f2) r_f2_data <= vrom_bus.rom_data;
      if (w_ret_f3) r_f3_data <= vrom_bus.rom_data;
    end
  end

  assign vrom_bus.f2_gnt    = r_f2_gnt;
  assign vrom_bus.f3_gnt    = r_f3_gnt;
  assign vrom_bus.f2_valid  = r_f2_valid;
  assign vrom_bus.f3_valid  = r_f3_valid;
  assign vrom_bus.f2_data   = r_f2_data;
  assign vrom_bus.f3_data   = r_f3_data;
  assign vrom_bus.rom_en    = r_rom_en;
  assign vrom_bus.rom_addr  = r_rom_addr;
  assign vrom_bus.rom_index = r_rom_index;

endmodule

// File: tb/tb_vrom_arbiter.sv
// Purpose: checks vrom_arbiter at ROM_LAT 1..4 side by side against a grant/return model.
// Latency: expects gnt one cycle after req and valid at gnt+ROM_LAT+1.
// Backpressure: none; the bench accepts every valid pulse.
module tb_vrom_arbiter;
  localparam int AW = 8;
  localparam int IW = 3;
  localparam int CW = 3;
  localparam int NL = 4;

  logic sysclk = 1'b0;
  logic rst_n;
  always #5 sysclk = ~sysclk;

  // Requester drive, index 0 = func2, 1 = func3
  logic          d_req  [2];
  logic          d_en   [2];
  logic [AW-1:0] d_addr [2];
  logic [IW-1:0] d_idx  [2];

  logic [NL-1:0]         o_f2_gnt, o_f3_gnt, o_rom_en, o_f2_valid, o_f3_valid;
  logic [NL-1:0][AW-1:0] o_rom_addr;
  logic [NL-1:0][IW-1:0] o_rom_index;
  logic [NL-1:0][CW-1:0] o_f2_data, o_f3_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Image contents as seen by the bench
  function automatic logic [CW-1:0] rom_fn(input logic [AW-1:0] a, input logic [IW-1:0] i);
    return a[2:0] ^ a[5:3] ^ {1'b0, a[7:6]} ^ i;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lat
    vrom_arbiter_if #(.AW(AW), .IW(IW), .CW(CW)) bus ();
    vrom_arbiter #(.ROM_LAT(g + 1), .AW(AW), .IW(IW), .CW(CW)) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .vrom_bus (bus)
    );
    logic [CW-1:0] rom_pipe [NL];

    assign bus.en_f2    = d_en[0];
    assign bus.en_f3    = d_en[1];
    assign bus.f2_req   = d_req[0];
    assign bus.f3_req   = d_req[1];
    assign bus.f2_addr  = d_addr[0];
    assign bus.f3_addr  = d_addr[1];
    assign bus.f2_index = d_idx[0];
    assign bus.f3_index = d_idx[1];
    assign bus.rom_data = rom_pipe[g];

    assign o_f2_gnt[g]    = bus.f2_gnt;
    assign o_f3_gnt[g]    = bus.f3_gnt;
    assign o_rom_en[g]    = bus.rom_en;
    assign o_rom_addr[g]  = bus.rom_addr;
    assign o_rom_index[g] = bus.rom_index;
    assign o_f2_valid[g]  = bus.f2_valid;
    assign o_f3_valid[g]  = bus.f3_valid;
    assign o_f2_data[g]   = bus.f2_data;
    assign o_f3_data[g]   = bus.f3_data;

    // ROM with g+1 cycles of latency; junk on the bus when not reading
    always @(posedge sysclk) begin
      rom_pipe[0] <= bus.rom_en ? rom_fn(bus.rom_addr, bus.rom_index) : CW'($urandom);
      for (int s = 1; s < NL; s++) rom_pipe[s] <= rom_pipe[s-1];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            lat;
    bit            own;
    logic [CW-1:0] data;
  } ret_t;

  bit            m_gnt [2];
  bit            m_rom_en;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_idx;
  bit            m_last;        // 1 = func3 owned the ROM last
  bit            m_v2 [NL];
  bit            m_v3 [NL];
  logic [CW-1:0] m_d2 [NL];
  logic [CW-1:0] m_d3 [NL];
  ret_t          rq [$];

  task automatic model_reset();
    m_gnt[0] = 0; m_gnt[1] = 0; m_rom_en = 0;
    m_addr = '0; m_idx = '0; m_last = 1;
    for (int k = 0; k < NL; k++) begin
      m_v2[k] = 0; m_v3[k] = 0; m_d2[k] = '0; m_d3[k] = '0;
    end
    rq.delete();
  endtask

  // Advance one clock: decide the winner from this cycle's inputs, then move to the next cycle
  task automatic tick();
    bit e0, e1, w0, w1;
    logic [AW-1:0] a;
    logic [IW-1:0] ix;
    e0 = d_req[0] & d_en[0] & ~m_gnt[0];
    e1 = d_req[1] & d_en[1] & ~m_gnt[1];
    w0 = e0 & (~e1 | m_last);
    w1 = e1 & ~w0;
    a  = w0 ? d_addr[0] : d_addr[1];
    ix = w0 ? d_idx[0]  : d_idx[1];
    @(posedge sysclk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_gnt[0] = w0; m_gnt[1] = w1; m_rom_en = w0 | w1;
      if (m_rom_en) begin
        m_addr = a; m_idx = ix; m_last = w1;
        for (int k = 0; k < NL; k++)
          rq.push_back('{due: cyc + k + 2, lat: k, own: w1, data: rom_fn(a, ix)});
      end
      for (int k = 0; k < NL; k++) begin m_v2[k] = 0; m_v3[k] = 0; end
      for (int i = rq.size() - 1; i >= 0; i--) begin
        if (rq[i].due == cyc) begin
          if (rq[i].own) begin m_v3[rq[i].lat] = 1; m_d3[rq[i].lat] = rq[i].data; end
          else           begin m_v2[rq[i].lat] = 1; m_d2[rq[i].lat] = rq[i].data; end
          rq.delete(i);
        end
      end
    end
    #1;
  endtask

  function automatic logic [21:0] act_vec(input int k);
    return {o_f2_gnt[k], o_f3_gnt[k], o_rom_en[k], o_rom_addr[k], o_rom_index[k],
            o_f2_valid[k], o_f2_data[k], o_f3_valid[k], o_f3_data[k]};
  endfunction

  function automatic logic [21:0] exp_vec(input int k);
    return {m_gnt[0], m_gnt[1], m_rom_en, m_addr, m_idx, m_v2[k], m_d2[k], m_v3[k], m_d3[k]};
  endfunction

  task automatic idle(input int n);
    d_req[0] = 0; d_req[1] = 0;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int k = 0; k < NL; k++) begin
      n_cmp++;
      if (act_vec(k) !== 22'h0) begin
        n_bad++; $display("FAIL reset_state lat=%0d got %h want %h", k + 1, act_vec(k), 22'h0);
      end
    end
    rst_n = 1;
    for (int r = 0; r < 2; r++) begin
      d_req[r] = 1; d_addr[r] = AW'($urandom); d_idx[r] = IW'($urandom);
    end
    repeat (3) tick();
    rst_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < NL; k++) begin
      n_cmp++;
      if (act_vec(k) !== 22'h0) begin
        n_bad++; $display("FAIL reset_async lat=%0d got %h want %h", k + 1, act_vec(k), 22'h0);
      end
    end
    d_req[0] = 0; d_req[1] = 0;
    repeat (2) tick();
    rst_n = 1;
    repeat (8) begin
      tick();
      for (int k = 0; k < NL; k++) begin
        n_cmp++;
        if ({o_f2_valid[k], o_f3_valid[k], o_f2_gnt[k], o_f3_gnt[k], o_rom_en[k]} !== 5'b0) begin
          n_bad++;
          $display("FAIL reset_no_valid lat=%0d cyc=%0d got %b want 00000", k + 1, cyc,
                   {o_f2_valid[k], o_f3_valid[k], o_f2_gnt[k], o_f3_gnt[k], o_rom_en[k]});
        end
      end
    end
  endtask

  task automatic test_single_read();
    idle(6);
    d_req[0] = 1; d_addr[0] = 8'h2A; d_idx[0] = 3'd3;
    tick();
    n_cmp++;
    if ({o_f2_gnt[0], o_f3_gnt[0], o_rom_en[0], o_rom_addr[0], o_rom_index[0]} !== {3'b101, 8'h2A, 3'd3}) begin
      n_bad++;
      $display("FAIL single_gnt got %h want %h",
               {o_f2_gnt[0], o_f3_gnt[0], o_rom_en[0], o_rom_addr[0], o_rom_index[0]}, {3'b101, 8'h2A, 3'd3});
    end
    d_req[0] = 0;
    tick();
    n_cmp++;
    if (o_f2_valid[0] !== 1'b0) begin
      n_bad++; $display("FAIL single_early got %b want 0", o_f2_valid[0]);
    end
    tick();
    n_cmp++;
    if ({o_f2_valid[0], o_f2_data[0], o_f3_valid[0]} !== {1'b1, rom_fn(8'h2A, 3'd3), 1'b0}) begin
      n_bad++;
      $display("FAIL single_valid got %b want %b", {o_f2_valid[0], o_f2_data[0], o_f3_valid[0]},
               {1'b1, rom_fn(8'h2A, 3'd3), 1'b0});
    end
    tick();
    n_cmp++;
    if ({o_f2_valid[0], o_f2_data[0], o_rom_en[0], o_rom_addr[0]} !== {1'b0, rom_fn(8'h2A, 3'd3), 1'b0, 8'h2A}) begin
      n_bad++;
      $display("FAIL single_hold got %h want %h", {o_f2_valid[0], o_f2_data[0], o_rom_en[0], o_rom_addr[0]},
               {1'b0, rom_fn(8'h2A, 3'd3), 1'b0, 8'h2A});
    end
  endtask

  task automatic test_contention();
    logic [AW-1:0] pa0, pa1, ea;
    bit eg2;
    rst_n = 0;
    model_reset();
    d_req[0] = 0; d_req[1] = 0;
    repeat (2) tick();
    rst_n = 1;
    for (int r = 0; r < 2; r++) begin
      d_req[r] = 1; d_addr[r] = AW'($urandom); d_idx[r] = IW'($urandom);
    end
    for (int k = 1; k <= 12; k++) begin
      pa0 = d_addr[0]; pa1 = d_addr[1];
      tick();
      eg2 = (k % 2 == 1);
      ea  = eg2 ? pa0 : pa1;
      n_cmp++;
      if ({o_f2_gnt[0], o_f3_gnt[0], o_rom_en[0], o_rom_addr[0]} !== {eg2, ~eg2, 1'b1, ea}) begin
        n_bad++;
        $display("FAIL contention_gnt k=%0d got %h want %h", k,
                 {o_f2_gnt[0], o_f3_gnt[0], o_rom_en[0], o_rom_addr[0]}, {eg2, ~eg2, 1'b1, ea});
      end
      n_cmp++;
      if ({o_f2_valid[0], o_f2_data[0], o_f3_valid[0], o_f3_data[0]} !== {m_v2[0], m_d2[0], m_v3[0], m_d3[0]}) begin
        n_bad++;
        $display("FAIL contention_ret k=%0d got %b want %b", k,
                 {o_f2_valid[0], o_f2_data[0], o_f3_valid[0], o_f3_data[0]}, {m_v2[0], m_d2[0], m_v3[0], m_d3[0]});
      end
      if (eg2) d_addr[0] = AW'($urandom);
      else     d_addr[1] = AW'($urandom);
    end
  endtask

  task automatic test_lone();
    logic [AW-1:0] la [3];
    logic [IW-1:0] ix;
    bit eg, ev;
    idle(8);
    ix = IW'($urandom);
    la[0] = AW'($urandom);
    d_idx[1] = ix; d_addr[1] = la[0]; d_req[1] = 1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      eg = (k == 1 || k == 3 || k == 5);
      ev = (k == 3 || k == 5 || k == 7);
      n_cmp++;
      if ({o_f2_gnt[0], o_f3_gnt[0]} !== {1'b0, eg}) begin
        n_bad++; $display("FAIL lone_gnt k=%0d got %b want %b", k, {o_f2_gnt[0], o_f3_gnt[0]}, {1'b0, eg});
      end
      n_cmp++;
      if (ev) begin
        if ({o_f3_valid[0], o_f3_data[0]} !== {1'b1, rom_fn(la[(k - 3) / 2], ix)}) begin
          n_bad++;
          $display("FAIL lone_ret k=%0d got %b want %b", k, {o_f3_valid[0], o_f3_data[0]},
                   {1'b1, rom_fn(la[(k - 3) / 2], ix)});
        end
      end else if (o_f3_valid[0] !== 1'b0) begin
        n_bad++; $display("FAIL lone_quiet k=%0d got %b want 0", k, o_f3_valid[0]);
      end
      if (k == 1 || k == 3) begin
        la[(k + 1) / 2] = la[(k - 1) / 2] + 8'd1 + AW'($urandom_range(0, 200));
        d_addr[1] = la[(k + 1) / 2];
      end
      if (k == 6) d_req[1] = 0;
    end
  endtask

  task automatic test_masking();
    logic [AW-1:0] a;
    logic [IW-1:0] ix;
    idle(6);
    a = AW'($urandom); ix = IW'($urandom);
    d_en[0] = 0;
    d_req[0] = 1; d_addr[0] = a; d_idx[0] = ix;
    d_req[1] = 1; d_addr[1] = AW'($urandom); d_idx[1] = IW'($urandom);
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if ({o_f2_gnt[0], o_f3_gnt[0]} !== {1'b0, (k % 2 == 1)}) begin
        n_bad++;
        $display("FAIL mask_gnt k=%0d got %b want %b", k, {o_f2_gnt[0], o_f3_gnt[0]}, {1'b0, (k % 2 == 1)});
      end
    end
    d_req[1] = 0; d_en[0] = 1;
    tick();
    n_cmp++;
    if ({o_f2_gnt[0], o_rom_addr[0]} !== {1'b1, a}) begin
      n_bad++; $display("FAIL unmask_gnt got %h want %h", {o_f2_gnt[0], o_rom_addr[0]}, {1'b1, a});
    end
    d_en[0] = 0; d_req[0] = 0;
    repeat (2) tick();
    n_cmp++;
    if ({o_f2_valid[0], o_f2_data[0]} !== {1'b1, rom_fn(a, ix)}) begin
      n_bad++;
      $display("FAIL masked_return got %b want %b", {o_f2_valid[0], o_f2_data[0]}, {1'b1, rom_fn(a, ix)});
    end
    d_en[0] = 1;
  endtask

  task automatic test_latency_sweep();
    d_en[0] = 1; d_en[1] = 1;
    idle(8);
    for (int it = 0; it < 400; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (it >= 390) begin
          d_req[r] = 0;
        end else if (m_gnt[r]) begin
          d_req[r] = ($urandom_range(0, 3) != 0);
          d_addr[r] = AW'($urandom); d_idx[r] = IW'($urandom);
        end else if (d_req[r]) begin
          if ($urandom_range(0, 15) == 0) d_req[r] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          d_req[r] = 1; d_addr[r] = AW'($urandom); d_idx[r] = IW'($urandom);
        end
        if (it < 390 && $urandom_range(0, 19) == 0) d_en[r] = ~d_en[r];
      end
      tick();
      for (int k = 0; k < NL; k++) begin
        n_cmp++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL sweep lat=%0d cyc=%0d got %h want %h", k + 1, cyc, act_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    rst_n = 0;
    for (int r = 0; r < 2; r++) begin
      d_req[r] = 0; d_en[r] = 1; d_addr[r] = '0; d_idx[r] = '0;
    end
    model_reset();
    repeat (3) tick();
    test_reset();
    test_single_read();
    test_contention();
    test_lone();
    test_masking();
    test_latency_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
